// File: rtl/dm_abstract_seq.sv
// rtl/dm_abstract_seq.sv - debug-module abstract command sequencer (IDLE/EXEC/POST)
// Validates command writes, drives exec/command to the core, tracks busy/cmderr and regno postincrement.
module dm_abstract_seq #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmderr_w1c,
  input  logic [2:0]  cmderr_wdata,
  input  logic        halted,
  input  logic        done,
  input  logic        error,
  output logic        exec,
  output logic [31:0] command,
  output logic        busy,
  output logic [2:0]  cmderr
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] ERR_BUSY      = 3'd1;
  localparam logic [2:0] ERR_NOTSUP    = 3'd2;
  localparam logic [2:0] ERR_EXCEPTION = 3'd3;
  localparam logic [2:0] ERR_HALTRESUME = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_POST
  } state_e;

  state_e        state_q, state_d;
  logic          exec_q, exec_d;
  logic          busy_q, busy_d;
  logic [2:0]    cmderr_q, cmderr_d;
  logic [31:0]   command_q, command_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          err_set;
  logic [2:0]    err_val;

  logic [7:0]    wr_type;
  logic [2:0]    wr_size;
  logic          wr_transfer;
  logic          wr_unsupported;

  assign wr_type        = cmd_wdata[31:24];
  assign wr_size        = cmd_wdata[22:20];
  assign wr_transfer    = cmd_wdata[17];
  // Register access only supports 32-bit; memory access supports 8/16/32-bit.
  assign wr_unsupported = !((wr_type == 8'd0) || (wr_type == 8'd2)) || (wr_size > 3'd2) ||
                          ((wr_type == 8'd0) && (wr_size != 3'd2));

  always_comb begin
    state_d   = state_q;
    command_d = command_q;
    timer_d   = timer_q;
    err_set   = 1'b0;
    err_val   = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (cmd_wr && (cmderr_q == 3'd0)) begin
          if (wr_unsupported) begin
            err_set = 1'b1;
            err_val = ERR_NOTSUP;
          end else if (!halted) begin
            err_set = 1'b1;
            err_val = ERR_HALTRESUME;
          end else if ((wr_type == 8'd0) && !wr_transfer) begin
            command_d = cmd_wdata;
            state_d   = S_POST;
          end else begin
            command_d = cmd_wdata;
            timer_d   = '0;
            state_d   = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        timer_d = timer_q + 1'b1;
        if (done) begin
          if (error) begin
            err_set = 1'b1;
            err_val = ERR_EXCEPTION;
            state_d = S_IDLE;
          end else begin
            state_d = S_POST;
          end
        end else if (!halted) begin
          err_set = 1'b1;
          err_val = ERR_HALTRESUME;
          state_d = S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
          state_d = S_IDLE;
        end
      end

      S_POST: begin
        if ((command_q[31:24] == 8'd0) && command_q[19]) begin
          command_d[15:0] = command_q[15:0] + 16'd1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A DMI write landing mid-sequence is rejected without disturbing the command.
    if (cmd_wr && (state_q != S_IDLE)) begin
      err_set = 1'b1;
      err_val = ERR_BUSY;
    end

    cmderr_d = cmderr_q;
    if (cmderr_w1c) begin
      cmderr_d = cmderr_q & ~cmderr_wdata;
    end
    if (err_set && (cmderr_q == 3'd0)) begin
      cmderr_d = err_val;
    end

    exec_d = (state_d == S_EXEC);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      exec_q    <= 1'b0;
      busy_q    <= 1'b0;
      cmderr_q  <= 3'd0;
      command_q <= 32'd0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      exec_q    <= exec_d;
      busy_q    <= busy_d;
      cmderr_q  <= cmderr_d;
      command_q <= command_d;
      timer_q   <= timer_d;
    end
  end

  assign exec    = exec_q;
  assign busy    = busy_q;
  assign cmderr  = cmderr_q;
  assign command = command_q;

endmodule

// File: tb/tb_dm_abstract_seq.sv
// tb/tb_dm_abstract_seq.sv - self-checking bench for dm_abstract_seq
module tb_dm_abstract_seq;

  localparam int TO  = 32;
  localparam int LIM = TO + 20;

  logic        clk;
  logic        rst_n;
  logic        cmd_wr;
  logic [31:0] cmd_wdata;
  logic        cmderr_w1c;
  logic [2:0]  cmderr_wdata;
  logic        halted;
  logic        done;
  logic        error;
  logic        exec;
  logic [31:0] command;
  logic        busy;
  logic [2:0]  cmderr;

  dm_abstract_seq #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_wr      (cmd_wr),
    .cmd_wdata   (cmd_wdata),
    .cmderr_w1c  (cmderr_w1c),
    .cmderr_wdata(cmderr_wdata),
    .halted      (halted),
    .done        (done),
    .error       (error),
    .exec        (exec),
    .command     (command),
    .busy        (busy),
    .cmderr      (cmderr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic        halted;
    int          done_at;
    logic        err;
    int          halt_drop;
    int          busy_wr_at;
    logic        clr;
    int          exp_exec;
    int          exp_low;
    logic [2:0]  exp_cmderr;
    logic [31:0] exp_cmd;
  } vec_t;

  typedef struct {
    int          exec_cnt;
    int          exec_last;
    int          busy_low;
    logic [2:0]  cmderr;
    logic [31:0] cmd;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic pulse_w1c(input logic [2:0] val);
    cmderr_w1c   = 1'b1;
    cmderr_wdata = val;
    @(negedge clk);
    cmderr_w1c   = 1'b0;
    cmderr_wdata = 3'd0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    int   k;
    bit   fell;
    if (v.clr) pulse_w1c(3'b111);
    e.exec_cnt  = v.exp_exec;
    e.exec_last = v.exp_exec;
    e.busy_low  = v.exp_low;
    e.cmderr    = v.exp_cmderr;
    e.cmd       = v.exp_cmd;
    sb.push_back(e);
    halted    = v.halted;
    cmd_wr    = 1'b1;
    cmd_wdata = v.cmd;
    @(negedge clk);
    cmd_wr = 1'b0;
    got.exec_cnt  = 0;
    got.exec_last = 0;
    got.busy_low  = 0;
    got.cmderr    = 3'd0;
    got.cmd       = 32'd0;
    fell = 1'b0;
    k = 1;
    while (!fell && k <= LIM) begin
      if (exec) begin
        got.exec_cnt++;
        got.exec_last = k;
      end
      if (!busy) begin
        fell         = 1'b1;
        got.busy_low = k;
        got.cmderr   = cmderr;
        got.cmd      = command;
      end else begin
        done      = (k == v.done_at);
        error     = v.err && (k == v.done_at);
        halted    = (v.halt_drop != 0 && k >= v.halt_drop) ? 1'b0 : v.halted;
        cmd_wr    = (k == v.busy_wr_at);
        cmd_wdata = (k == v.busy_wr_at) ? 32'h0022_7777 : v.cmd;
        @(negedge clk);
        k++;
      end
    end
    done   = 1'b0;
    error  = 1'b0;
    cmd_wr = 1'b0;
    halted = 1'b1;
    e = sb.pop_front();
    check($sformatf("v%0d exec_cnt", idx),  32'(got.exec_cnt),  32'(e.exec_cnt));
    check($sformatf("v%0d exec_last", idx), 32'(got.exec_last), 32'(e.exec_last));
    check($sformatf("v%0d busy_low", idx),  32'(got.busy_low),  32'(e.busy_low));
    check($sformatf("v%0d cmderr", idx),    32'(got.cmderr),    32'(e.cmderr));
    check($sformatf("v%0d command", idx),   got.cmd,            e.cmd);
  endtask

  initial begin
    //          cmd           hlt   done err  hdrop bwr clr   exec  low    cmderr  command
    vecs[0]  = '{32'h0022_1001, 1'b1, 3, 1'b0, 0, 0, 1'b1, 3,  5,      3'd0, 32'h0022_1001};
    vecs[1]  = '{32'h002A_1001, 1'b1, 2, 1'b0, 0, 0, 1'b0, 2,  4,      3'd0, 32'h002A_1002};
    vecs[2]  = '{32'h002A_1002, 1'b1, 1, 1'b0, 0, 0, 1'b0, 1,  3,      3'd0, 32'h002A_1003};
    vecs[3]  = '{32'h002A_FFFF, 1'b1, 1, 1'b0, 0, 0, 1'b0, 1,  3,      3'd0, 32'h002A_0000};
    vecs[4]  = '{32'h0022_1000, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0,  1,      3'd4, 32'h002A_0000};
    vecs[5]  = '{32'h0102_0000, 1'b1, 0, 1'b0, 0, 0, 1'b1, 0,  1,      3'd2, 32'h002A_0000};
    vecs[6]  = '{32'h0032_1000, 1'b1, 0, 1'b0, 0, 0, 1'b1, 0,  1,      3'd2, 32'h002A_0000};
    vecs[7]  = '{32'h0020_1000, 1'b1, 0, 1'b0, 0, 0, 1'b1, 0,  2,      3'd0, 32'h0020_1000};
    vecs[8]  = '{32'h0028_0005, 1'b1, 0, 1'b0, 0, 0, 1'b0, 0,  2,      3'd0, 32'h0028_0006};
    vecs[9]  = '{32'h021A_0000, 1'b1, 2, 1'b0, 0, 0, 1'b0, 2,  4,      3'd0, 32'h021A_0000};
    vecs[10] = '{32'h0022_2000, 1'b1, 2, 1'b1, 0, 0, 1'b0, 2,  3,      3'd3, 32'h0022_2000};
    vecs[11] = '{32'h0022_3000, 1'b1, 0, 1'b0, 0, 0, 1'b0, 0,  1,      3'd3, 32'h0022_2000};
    vecs[12] = '{32'h0022_3000, 1'b1, 0, 1'b0, 0, 0, 1'b1, TO, TO + 1, 3'd7, 32'h0022_3000};
    vecs[13] = '{32'h0022_4000, 1'b1, 0, 1'b0, 3, 0, 1'b1, 3,  4,      3'd4, 32'h0022_4000};
    vecs[14] = '{32'h0022_5000, 1'b1, 2, 1'b0, 2, 0, 1'b1, 2,  4,      3'd0, 32'h0022_5000};
    vecs[15] = '{32'h0022_6000, 1'b1, 3, 1'b1, 0, 2, 1'b1, 3,  4,      3'd1, 32'h0022_6000};

    rst_n        = 1'b1;
    cmd_wr       = 1'b0;
    cmd_wdata    = 32'd0;
    cmderr_w1c   = 1'b0;
    cmderr_wdata = 3'd0;
    halted       = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset exec",    32'(exec),   32'd0);
    check("reset busy",    32'(busy),   32'd0);
    check("reset cmderr",  32'(cmderr), 32'd0);
    check("reset command", command,     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_vec(i, vecs[i]);
      @(negedge clk);
    end

    // cmderr is 1 here; clearing an unset bit leaves it, clearing the set bit zeroes it.
    pulse_w1c(3'b110);
    check("w1c other bits", 32'(cmderr), 32'd1);
    pulse_w1c(3'b001);
    check("w1c clear", 32'(cmderr), 32'd0);

    cmd_wr       = 1'b1;
    cmd_wdata    = 32'h0102_0000;
    cmderr_w1c   = 1'b1;
    cmderr_wdata = 3'b111;
    @(negedge clk);
    cmd_wr     = 1'b0;
    cmderr_w1c = 1'b0;
    check("clear vs new error", 32'(cmderr), 32'd2);
    pulse_w1c(3'b111);
    check("clear before reset seq", 32'(cmderr), 32'd0);

    cmd_wr    = 1'b1;
    cmd_wdata = 32'h0022_1234;
    @(negedge clk);
    cmd_wdata = 32'h0022_9999;
    @(negedge clk);
    cmd_wr = 1'b0;
    check("busy wr exec",    32'(exec),   32'd1);
    check("busy wr busy",    32'(busy),   32'd1);
    check("busy wr cmderr",  32'(cmderr), 32'd1);
    check("busy wr command", command,     32'h0022_1234);
    #2 rst_n = 1'b0;
    #1;
    check("async rst exec",    32'(exec),   32'd0);
    check("async rst busy",    32'(busy),   32'd0);
    check("async rst cmderr",  32'(cmderr), 32'd0);
    check("async rst command", command,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
